// File: rtl/subtractor_arbiter.sv
// Two-requester arbiter in front of one shared 4-bit subtractor with registered results.
// Latency: grant one cycle after request is sampled, done one cycle after grant.
// Backpressure: losing requester waits in IDLE; the owner releases by dropping its req.
module subtractor_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic [3:0] a0,
    input  logic [3:0] b0,
    input  logic [3:0] a1,
    input  logic [3:0] b1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic [3:0] diff,
    output logic [3:0] magnitude,
    output logic       negative,
    output logic       busy,
    output logic [7:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    logic       prio1;
    logic [3:0] op_a;
    logic [3:0] op_b;
    logic [4:0] sub_res;
    logic [3:0] sub_mag;
    logic       pick1;
    logic       gnt_req;

    // Single subtractor; the extra top bit is the borrow-out, i.e. a < b.
    assign sub_res = {1'b0, op_a} - {1'b0, op_b};
    assign sub_mag = sub_res[4] ? (~sub_res[3:0] + 4'd1) : sub_res[3:0];

    assign pick1   = req1 & (~req0 | (RR_EN & prio1));
    assign gnt_req = (gnt0 & req0) | (gnt1 & req1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            prio1     <= 1'b0;
            op_a      <= 4'd0;
            op_b      <= 4'd0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            diff      <= 4'd0;
            magnitude <= 4'd0;
            negative  <= 1'b0;
            busy      <= 1'b0;
            op_count  <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 | req1) begin
                        op_a  <= pick1 ? a1 : a0;
                        op_b  <= pick1 ? b1 : b0;
                        gnt0  <= ~pick1;
                        gnt1  <= pick1;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (gnt_req) begin
                        diff      <= sub_res[3:0];
                        magnitude <= sub_mag;
                        negative  <= sub_res[4];
                        done0     <= gnt0;
                        done1     <= gnt1;
                        op_count  <= op_count + 8'd1;
                        state     <= DONE;
                    end else begin
                        // Abandoned grant still counts as service for fairness.
                        prio1 <= gnt0;
                        gnt0  <= 1'b0;
                        gnt1  <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                DONE: begin
                    if (!gnt_req) begin
                        prio1 <= gnt0;
                        gnt0  <= 1'b0;
                        gnt1  <= 1'b0;
                        done0 <= 1'b0;
                        done1 <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_subtractor_arbiter.sv
// Directed bench: round-robin and fixed-priority instances share stimulus.
module tb_subtractor_arbiter;

    logic       clk = 1'b0;
    logic       rst, req0, req1;
    logic [3:0] a0, b0, a1, b1;

    logic       rr_gnt0, rr_gnt1, rr_done0, rr_done1, rr_neg, rr_busy;
    logic [3:0] rr_diff, rr_mag;
    logic [7:0] rr_cnt;
    logic       fp_gnt0, fp_gnt1, fp_done0, fp_done1, fp_neg, fp_busy;
    logic [3:0] fp_diff, fp_mag;
    logic [7:0] fp_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    subtractor_arbiter #(.RR_EN(1'b1)) u_rr (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(rr_gnt0), .gnt1(rr_gnt1), .done0(rr_done0), .done1(rr_done1),
        .diff(rr_diff), .magnitude(rr_mag), .negative(rr_neg),
        .busy(rr_busy), .op_count(rr_cnt)
    );

    subtractor_arbiter #(.RR_EN(1'b0)) u_fp (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(fp_gnt0), .gnt1(fp_gnt1), .done0(fp_done0), .done1(fp_done1),
        .diff(fp_diff), .magnitude(fp_mag), .negative(fp_neg),
        .busy(fp_busy), .op_count(fp_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        a0 = 4'd0; b0 = 4'd0; a1 = 4'd0; b1 = 4'd0;
        tick(); tick();
        check("rst_outs", {rr_gnt0, rr_gnt1, rr_done0, rr_done1, rr_neg, rr_busy}, 0);
        check("rst_data", {rr_diff, rr_mag, rr_cnt}, 0);
        rst = 1'b0;
        tick();
        check("idle_hold", {rr_gnt0, rr_gnt1, rr_busy, rr_cnt}, 0);

        // 9 - 3 on requester 0
        req0 = 1'b1; a0 = 4'd9; b0 = 4'd3;
        tick();
        check("r0_gnt", {rr_gnt0, rr_gnt1, rr_done0, rr_busy}, 4'b1001);
        tick();
        check("r0_done", {rr_gnt0, rr_done0, rr_done1}, 3'b110);
        check("r0_diff", rr_diff, 6);
        check("r0_mag", rr_mag, 6);
        check("r0_neg", rr_neg, 0);
        check("r0_cnt", rr_cnt, 1);
        req0 = 1'b0;
        tick();
        check("r0_release", {rr_gnt0, rr_done0, rr_busy}, 0);
        check("r0_hold", rr_diff, 6);

        // 3 - 9 on requester 1
        req1 = 1'b1; a1 = 4'd3; b1 = 4'd9;
        tick();
        check("r1_gnt", {rr_gnt0, rr_gnt1}, 2'b01);
        tick();
        check("r1_done", {rr_done0, rr_done1}, 2'b01);
        check("r1_diff", rr_diff, 10);
        check("r1_mag", rr_mag, 6);
        check("r1_neg", rr_neg, 1);
        check("r1_cnt", rr_cnt, 2);
        req1 = 1'b0;
        tick();

        // two back-to-back ties; operands 9-3 and 3-9 still on the buses
        a0 = 4'd9; b0 = 4'd3;
        req0 = 1'b1; req1 = 1'b1;
        tick();
        check("tie1_rr", {rr_gnt0, rr_gnt1}, 2'b10);
        check("tie1_fp", {fp_gnt0, fp_gnt1}, 2'b10);
        tick();
        req0 = 1'b0; req1 = 1'b0;
        tick();
        req0 = 1'b1; req1 = 1'b1;
        tick();
        check("tie2_rr", {rr_gnt0, rr_gnt1}, 2'b01);
        check("tie2_fp", {fp_gnt0, fp_gnt1}, 2'b10);
        tick();
        check("tie2_rr_diff", rr_diff, 10);
        check("tie2_fp_diff", fp_diff, 6);
        check("tie2_cnt", rr_cnt, 4);
        req0 = 1'b0; req1 = 1'b0;
        tick();

        // abandon during CALC
        req0 = 1'b1; a0 = 4'd7; b0 = 4'd2;
        tick();
        check("abn_gnt", rr_gnt0, 1);
        req0 = 1'b0;
        tick();
        check("abn_idle", {rr_gnt0, rr_done0, rr_busy}, 0);
        check("abn_cnt", rr_cnt, 4);
        check("abn_diff", rr_diff, 10);
        tick();
        check("abn_nodone", rr_done0, 0);

        // operands latched at grant; later changes ignored
        req0 = 1'b1; a0 = 4'd5; b0 = 4'd5;
        tick();
        a0 = 4'd15;
        tick();
        check("lat_diff", rr_diff, 0);
        check("lat_neg", rr_neg, 0);
        check("lat_cnt", rr_cnt, 5);
        tick();
        check("done_hold", {rr_gnt0, rr_done0, rr_busy}, 3'b111);

        // reset in DONE
        rst = 1'b1; req0 = 1'b0;
        tick();
        check("rstdone_outs", {rr_gnt0, rr_gnt1, rr_done0, rr_done1, rr_neg, rr_busy}, 0);
        check("rstdone_data", {rr_diff, rr_mag, rr_cnt}, 0);
        rst = 1'b0;
        tick();

        // pointer back to requester 0 after reset (a1-b1 is 3-9)
        req0 = 1'b1; req1 = 1'b1; a0 = 4'd1; b0 = 4'd0;
        tick();
        check("rst_ptr", {rr_gnt0, rr_gnt1}, 2'b10);
        tick();
        req0 = 1'b0; req1 = 1'b0;
        tick();

        // 255 more completions: count reaches 255 then wraps
        for (int i = 0; i < 255; i++) begin
            if (i == 254) check("cnt_255", rr_cnt, 255);
            req0 = 1'b1;
            tick(); tick();
            req0 = 1'b0;
            tick();
        end
        check("cnt_wrap", rr_cnt, 0);
        check("wrap_diff", rr_diff, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/subtractor_arbiter.md
SUBTRACTOR_ARBITER -- requirements
Module: subtractor_arbiter

Interface
REQ-001 Parameter: RR_EN, default 1, 1 = round-robin tie-break, 0 = fixed priority to requester 0.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0, req1  input  1 each  operation request from requester 0 / 1, level, held until done or abandoned.
REQ-005 a0, b0  input  4 each  minuend / subtrahend of requester 0, stable while req0 high.
REQ-006 a1, b1  input  4 each  minuend / subtrahend of requester 1, stable while req1 high.
REQ-007 gnt0, gnt1  output  1 each  requester owns the shared subtractor; at most one high.
REQ-008 done0, done1  output  1 each  result valid for that requester.
REQ-009 diff  output  4  raw difference (a - b) mod 16.
REQ-010 magnitude  output  4  |a - b|, range 0..15.
REQ-011 negative  output  1  1 when a < b unsigned.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 op_count  output  8  completed-operation counter.

Function
REQ-014 Block SHALL contain exactly one 4-bit subtractor shared by both requesters, with no borrow-in.
REQ-015 FSM states SHALL be IDLE, CALC and DONE only.
REQ-016 IDLE with no request: state SHALL remain IDLE and all outputs SHALL hold their values.
REQ-017 IDLE with any req high: next edge SHALL latch the winner's a/b into operand registers, set its gnt and enter CALC.
REQ-018 Tie in IDLE with RR_EN=1: winner SHALL be the requester not granted most recently; the pointer after reset SHALL favour requester 0.
REQ-019 Tie with RR_EN=0: requester 0 SHALL always win.
REQ-020 CALC with granted req high: next edge SHALL register diff, magnitude and negative from the operand registers, set the matching done, increment op_count and enter DONE.
REQ-021 Latency: gnt SHALL be high the cycle after req is first sampled, and done one cycle later (2 cycles from request edge to done).
REQ-022 CALC with granted req low (abandon): next edge SHALL enter IDLE, clear gnt, leave result outputs and op_count unchanged and assert no done.
REQ-023 DONE: gnt and done SHALL stay high while the granted req stays high.
REQ-024 DONE with granted req low: next edge SHALL clear gnt and done, update the round-robin pointer to the served requester and enter IDLE.
REQ-025 An abandoned grant SHALL also update the pointer.
REQ-026 Non-granted requests SHALL wait and never preempt.
REQ-027 diff SHALL equal (a - b) mod 16.
REQ-028 negative SHALL equal (a < b).
REQ-029 magnitude SHALL equal diff when negative=0, and (~diff + 1) mod 16 when negative=1.
REQ-030 diff, magnitude and negative SHALL hold the last completed result until the next completion.
REQ-031 op_count SHALL wrap from 255 to 0.
REQ-032 Operand changes after the IDLE-to-CALC edge SHALL NOT affect the result.
REQ-033 busy SHALL be high in CALC and DONE.

Reset
REQ-034 rst high at a clock edge SHALL force IDLE, all outputs to 0 and the pointer to favour requester 0.
REQ-035 Reset SHALL take precedence over every other event, including mid-CALC or mid-DONE; an interrupted operation SHALL produce no done and no count.

Verification
REQ-036 req0 with a0=9, b0=3 -> gnt0 at +1 cycle; at +2 cycles done0=1, diff=6, magnitude=6, negative=0, op_count=1.
REQ-037 req1 with a1=3, b1=9 -> done1=1, diff=10, magnitude=6, negative=1.
REQ-038 req0 and req1 asserted together, twice in a row with RR_EN=1 -> first grant to 0, second to 1; with RR_EN=0 -> both grants to 0.
REQ-039 Grant requester 0, drop req0 during CALC -> IDLE next edge, done0 never high, results and op_count unchanged.
REQ-040 rst pulsed during DONE -> all outputs 0 next edge; with 256 completed operations (no reset between) -> op_count=0.
REQ-041 Change a0 to 15 in CALC after latching a0=5, b0=5 -> diff=0, negative=0.
